i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- I2C target (responder) for the i2c_wrapper initiator path: decodes SCL/SDA from the bus and serves a byte-wide register file.
- The initiator side writes and reads this register file at ADDRWIDTH-bit register addresses.
- Together the two ends form a closed loop: wrapper writes bytes over I2C, this block stores them, and later returns them on read.
- Runs on the system clock, oversamples the bus and never drives SCL (no clock stretching).

Parameters:
- DATAWIDTH, 8, register width; fixed at 8 for I2C byte framing.
- ADDRWIDTH, 6, register address width; the register file holds 2**ADDRWIDTH entries.
- DEV_ADDR, 7'h50, 7-bit target device address.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock, asynchronous to clk.
- sda_in  input  1  bus data as sampled from the pad, asynchronous to clk.
- sda_oe  output  1  open-drain enable; 1 pulls SDA low, 0 releases it to Z.
- busy  output  1  high from START to STOP while a transaction addressed to this target is active.
- reg_wr  output  1  one-clk pulse when a data byte is committed to the register file.
- reg_addr  output  ADDRWIDTH  register address of the current access.
- reg_wdata  output  DATAWIDTH  byte committed; valid while reg_wr is high.

Behaviour:
- Reset values: sda_oe=0, busy=0, reg_wr=0, reg_addr=0, reg_wdata=0, pointer=0, state=IDLE.
- Register file contents are not reset.
- Reset asserted mid-transaction releases SDA immediately and returns the block to IDLE.
- Bus sampling: scl and sda_in pass through 2-flop synchronizers plus one history flop.
  - Bus events are detected 3 clk after the pin change.
  - The bus requires SCL high/low phases of at least 4 clk.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Rise/fall: SCL edges.
  - START or STOP is recognised in every state and takes priority over bit processing.
- Data bits are sampled on SCL rise, MSB first.
- The target changes sda_oe only on a detected SCL fall, never while SCL is high.
- States: IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WRDATA, WRACK, RDDATA, RDACK, IGNORE.
- IDLE: on START go to DEVADDR, bit count 0.
- DEVADDR: shift 8 bits (7 address bits, then R/W).
  - On the 8th SCL fall, if the address equals DEV_ADDR, drive sda_oe=1 and go to DEVACK.
  - Otherwise go to IGNORE with SDA released.
- DEVACK: hold ACK low through the 9th clock. On the 9th SCL fall:
  - W=0: release SDA, go to REGADDR.
  - R=1: drive bit 7 of mem[pointer], go to RDDATA.
- REGADDR: shift 8 bits. pointer <= the received byte's low ADDRWIDTH bits; upper bits are ignored. ACK, then go to WRDATA.
- WRDATA: shift 8 bits, then ACK in WRACK.
  - At the 8th SCL fall: write mem[pointer], pulse reg_wr for 1 clk with reg_addr=pointer and reg_wdata=byte.
  - pointer increments modulo 2**ADDRWIDTH; 63 wraps to 0.
- RDDATA: drive each bit on SCL fall, MSB first.
  - A 0 bit drives sda_oe=1; a 1 bit releases.
  - After the 8th bit, release SDA for the initiator's ACK and go to RDACK.
- RDACK: sample SDA on the 9th SCL rise.
  - ACK (0): pointer increments modulo, drive bit 7 of the next byte on the following fall, go to RDDATA.
  - NACK (1): pointer still increments, go to IGNORE.
- IGNORE: SDA released; wait for START or STOP.
- Repeated START in any state: go to DEVADDR, pointer is kept. This supports a write of the register address followed by a restart read.
- STOP in any state: release SDA, busy=0, go to IDLE.
- A partial byte is discarded: no reg_wr is issued and the pointer is unchanged.
- busy is set on the DEVADDR→DEVACK transition and cleared on STOP, a non-matching repeated START, or reset.
- Never drive SDA in IDLE or IGNORE.
- Never change sda_oe at the same clk as a START/STOP detection.

Test Plan:
- Write: START, 0xA0, reg 0x0D, data 0xE5, STOP.
  - Expect ACK on all 3 bytes.
  - One reg_wr with reg_addr=0x0D, reg_wdata=0xE5.
  - busy falls after STOP.
- Read-back: START, 0xA0, 0x0D, repeated START, 0xA1, read 1 byte, NACK, STOP.
  - Expect 0xE5 returned and SDA released after the 8th bit.
- Wrap burst: write reg 0x3E with 0x11, 0x22, 0x33.
  - Expect writes at 0x3E, 0x3F, 0x00.
  - A subsequent read burst from 0x3E returns 0x11, 0x22, 0x33.
- Address mismatch: START, 0xA2, ... → no ACK, sda_oe stays 0 for the whole transaction, no reg_wr.
- Full sweep: write i to reg i for i=0..63, then read all 64 in one burst → data matches i, zero errors.
- Abort: assert reset after 4 data bits of a write → sda_oe=0 and busy=0 immediately, no reg_wr, target register unchanged.
  - A fresh transaction afterwards succeeds.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target serving a byte-wide register file.
// Oversamples SCL/SDA on the system clock and drives SDA open-drain only.
// It never stretches SCL.
// Handshake: reg_wr is a single-cycle valid strobe with no ready; reg_addr and
// reg_wdata are valid in the cycle reg_wr is high and must be consumed then.
module i2c_target_regfile #(
    parameter int         DATAWIDTH = 8,
    parameter int         ADDRWIDTH = 6,
    parameter logic [6:0] DEV_ADDR  = 7'h50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic                 busy,
    output logic                 reg_wr,
    output logic [ADDRWIDTH-1:0] reg_addr,
    output logic [DATAWIDTH-1:0] reg_wdata,
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DEVADDR = 4'd1,
        S_DEVACK  = 4'd2,
        S_REGADDR = 4'd3,
        S_REGACK  = 4'd4,
        S_WRDATA  = 4'd5,
        S_WRACK   = 4'd6,
        S_RDDATA  = 4'd7,
        S_RDACK   = 4'd8,
        S_IGNORE  = 4'd9
    } state_t;

    // Synchronizer chains: [0],[1] are the 2-flop synchronizer, [2] is history.
    logic [2:0]           scl_sync_q, sda_sync_q;
    state_t               state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATAWIDTH-1:0] shift_q, shift_d;
    logic [DATAWIDTH-1:0] tx_q, tx_d;
    logic                 rw_q, rw_d;
    logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 busy_q, busy_d;
    logic                 reg_wr_q, reg_wr_d;
    logic [ADDRWIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATAWIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic                 mem_we;
    logic [DATAWIDTH-1:0] mem_rdata;
    logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign scl_now  = scl_sync_q[1];
    assign scl_prev = scl_sync_q[2];
    assign sda_now  = sda_sync_q[1];
    assign sda_prev = sda_sync_q[2];
    assign scl_rise = scl_now & ~scl_prev;
    assign scl_fall = ~scl_now & scl_prev;
    assign start_ev = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_ev  = scl_now & scl_prev & ~sda_prev & sda_now;

    assign mem_rdata = mem[ptr_q];

    // Bus synchronizers; reset to the idle-high bus so no false event follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl};
            sda_sync_q <= {sda_sync_q[1:0], sda_in};
        end
    end

    // Register file storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= shift_q;
        end
    end

    // Protocol state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Next-state logic: START/STOP override bit processing; SDA only moves on SCL fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        mem_we      = 1'b0;

        if (start_ev) begin
            state_d   = S_DEVADDR;
            bit_cnt_d = 4'd0;
        end else if (stop_ev) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_DEVADDR, S_REGADDR, S_WRDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DATAWIDTH-2:0], sda_now};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == S_DEVADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                rw_d    = shift_q[0];
                                busy_d  = 1'b1;
                                state_d = S_DEVACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                                state_d  = S_IGNORE;
                            end
                        end else if (state_q == S_REGADDR) begin
                            ptr_d   = shift_q[ADDRWIDTH-1:0];
                            state_d = S_REGACK;
                        end else begin
                            mem_we      = 1'b1;
                            reg_wr_d    = 1'b1;
                            reg_addr_d  = ptr_q;
                            reg_wdata_d = shift_q;
                            ptr_d       = ptr_q + 1'b1;
                            state_d     = S_WRACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end
                end
                S_DEVACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            tx_d       = {mem_rdata[DATAWIDTH-2:0], 1'b0};
                            sda_oe_d   = ~mem_rdata[DATAWIDTH-1];
                            reg_addr_d = ptr_q;
                            bit_cnt_d  = 4'd1;
                            state_d    = S_RDDATA;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_REGADDR;
                        end
                    end
                end
                S_REGACK, S_WRACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_WRDATA;
                    end
                end
                S_RDDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RDACK;
                        end else begin
                            sda_oe_d  = ~tx_q[DATAWIDTH-1];
                            tx_d      = {tx_q[DATAWIDTH-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RDACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                        if (sda_now) begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall) begin
                        tx_d       = {mem_rdata[DATAWIDTH-2:0], 1'b0};
                        sda_oe_d   = ~mem_rdata[DATAWIDTH-1];
                        reg_addr_d = ptr_q;
                        bit_cnt_d  = 4'd1;
                        state_d    = S_RDDATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C initiator, register-file model,
// and a queue of expected register writes.
module tb_i2c_target_regfile;

    localparam int T = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe, busy, reg_wr;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [3:0] dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_model [64];
    int          ptr_model = 0;
    logic [13:0] exp_q[$];
    logic [7:0]  wr_bytes[$];
    int          wr_seen = 0;
    bit          oe_seen = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write scoreboard and SDA-activity monitor
    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (reg_wr === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_reg_wr observed=%0h expected=none", {reg_addr, reg_wdata});
                end
            end else begin
                check("reg_wr_addr_data", {18'd0, reg_addr, reg_wdata}, {18'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; clks(T);
        scl = 1'b1;   clks(T);
        sda_m = 1'b0; clks(T);
        scl = 1'b0;   clks(1);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; clks(T);
        scl = 1'b1;   clks(T);
        sda_m = 1'b1; clks(T);
    endtask

    task automatic put_bit(input bit b);
        sda_m = b;  clks(T);
        scl = 1'b1; clks(T);
        scl = 1'b0; clks(1);
    endtask

    task automatic get_bit(output bit b);
        sda_m = 1'b1; clks(T);
        scl = 1'b1;   clks(T / 2);
        b = sda_line; clks(T - T / 2);
        scl = 1'b0;   clks(1);
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input bit nack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        sda_m = nack; clks(T);
        check("rd_release_after_8th", {31'd0, sda_oe}, 0);
        scl = 1'b1;   clks(T);
        scl = 1'b0;   clks(1);
    endtask

    // Write the bytes in wr_bytes starting at register ra, one transaction.
    task automatic do_write(input logic [5:0] ra);
        bit         ack;
        logic [1:0] up;
        up = 2'($urandom_range(0, 3));
        bus_start();
        send_byte(8'hA0, ack);
        check("wr_devaddr_ack", {31'd0, ack}, 1);
        check("busy_after_match", {31'd0, busy}, 1);
        send_byte({up, ra}, ack);
        check("wr_regaddr_ack", {31'd0, ack}, 1);
        ptr_model = int'(ra);
        foreach (wr_bytes[k]) begin
            exp_q.push_back({6'(ptr_model), wr_bytes[k]});
            mem_model[ptr_model] = wr_bytes[k];
            send_byte(wr_bytes[k], ack);
            check("wr_data_ack", {31'd0, ack}, 1);
            ptr_model = (ptr_model + 1) % 64;
        end
        bus_stop();
        check("busy_after_stop", {31'd0, busy}, 0);
    endtask

    // Read n bytes; with set_ptr, first write the register address then restart.
    task automatic do_read(input bit set_ptr, input logic [5:0] ra, input int n);
        bit         ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            send_byte(8'hA0, ack);
            check("rd_devaddr_w_ack", {31'd0, ack}, 1);
            send_byte({2'b00, ra}, ack);
            check("rd_regaddr_ack", {31'd0, ack}, 1);
            ptr_model = int'(ra);
            bus_start();
        end
        send_byte(8'hA1, ack);
        check("rd_devaddr_r_ack", {31'd0, ack}, 1);
        for (int k = 0; k < n; k++) begin
            recv_byte(d, k == n - 1);
            check("rd_data", {24'd0, d}, {24'd0, mem_model[ptr_model]});
            ptr_model = (ptr_model + 1) % 64;
        end
        bus_stop();
        check("rd_busy_after_stop", {31'd0, busy}, 0);
    endtask

    // stimulus
    initial begin
        bit   ack;
        int   wr_before;
        int   ra_r;
        int   n_r;

        reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
        clks(4);
        check("rst_sda_oe", {31'd0, sda_oe}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_reg_wr", {31'd0, reg_wr}, 0);
        check("rst_reg_addr", {26'd0, reg_addr}, 0);
        check("rst_reg_wdata", {24'd0, reg_wdata}, 0);
        reset = 1'b0;
        clks(4);

        // single write then restart read-back
        wr_bytes = {};
        wr_bytes.push_back(8'hE5);
        do_write(6'h0D);
        do_read(1'b1, 6'h0D, 1);

        // wrap burst across the top of the register file
        wr_bytes = {};
        wr_bytes.push_back(8'h11);
        wr_bytes.push_back(8'h22);
        wr_bytes.push_back(8'h33);
        do_write(6'h3E);
        do_read(1'b1, 6'h3E, 3);

        // address mismatch: no ACK, SDA never driven, no writes
        wr_before = wr_seen;
        oe_seen = 1'b0;
        bus_start();
        send_byte(8'hA2, ack);
        check("mismatch_nack", {31'd0, ack}, 0);
        send_byte(8'h05, ack);
        check("mismatch_byte2_nack", {31'd0, ack}, 0);
        send_byte(8'h77, ack);
        bus_stop();
        check("mismatch_sda_never_driven", {31'd0, oe_seen}, 0);
        check("mismatch_no_reg_wr", wr_seen, wr_before);
        check("mismatch_busy", {31'd0, busy}, 0);

        // full sweep: reg i = i, then one 64-byte read burst
        wr_bytes = {};
        for (int i = 0; i < 64; i++) wr_bytes.push_back(8'(i));
        do_write(6'h00);
        do_read(1'b1, 6'h00, 64);

        // randomized writes and read-backs
        for (int r = 0; r < 6; r++) begin
            ra_r = $urandom_range(0, 63);
            n_r  = $urandom_range(1, 4);
            wr_bytes = {};
            for (int k = 0; k < n_r; k++) wr_bytes.push_back(8'($urandom_range(0, 255)));
            do_write(6'(ra_r));
            do_read(1'b1, 6'(ra_r), n_r);
        end

        // abort: reset after 4 data bits of a write to register 0x20
        wr_before = wr_seen;
        bus_start();
        send_byte(8'hA0, ack);
        check("abort_devaddr_ack", {31'd0, ack}, 1);
        send_byte(8'h20, ack);
        check("abort_regaddr_ack", {31'd0, ack}, 1);
        for (int i = 0; i < 4; i++) put_bit(1'b0);
        check("abort_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        check("abort_sda_oe", {31'd0, sda_oe}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        scl = 1'b1; sda_m = 1'b1;
        clks(3);
        reset = 1'b0;
        ptr_model = 0;
        clks(T);
        check("abort_no_reg_wr", wr_seen, wr_before);
        // pointer restarts at 0 after reset
        do_read(1'b0, 6'h00, 1);
        do_read(1'b1, 6'h20, 1);
        // fresh transaction after the abort
        wr_bytes = {};
        wr_bytes.push_back(8'(($urandom_range(0, 255))));
        wr_bytes.push_back(8'h5A);
        do_write(6'h20);
        do_read(1'b1, 6'h20, 2);

        clks(4);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
